// File: rtl/rdy_ack_serializer.sv
// Wide-to-narrow rdy/ack serializer: accepts one word per upstream handshake and
// emits it LSB-first as SEG_N_M1+1 segments, reloading on the last segment for zero bubbles.
module rdy_ack_serializer #(
    parameter int SEG_DW_M1 = 7,
    parameter int SEG_N_M1  = 3,
    parameter int IN_DW_M1  = 31,
    parameter int CW_M1     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rdy,
    output logic                 i_ack,
    input  logic [IN_DW_M1:0]    i_data,
    output logic                 o_rdy,
    input  logic                 o_ack,
    output logic [SEG_DW_M1:0]   o_data,
    output logic                 o_first,
    output logic                 o_last,
    output logic                 busy
);

    localparam int              SEG_W    = SEG_DW_M1 + 1;
    localparam int              CW       = CW_M1 + 1;
    localparam logic [CW_M1:0]  LAST_CNT = CW'(SEG_N_M1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IN_DW_M1:0]   shreg_q, shreg_d;
    logic [CW_M1:0]      seg_cnt_q, seg_cnt_d;
    logic                i_deal, o_deal;

    assign o_rdy   = (state_q == SEND);
    assign busy    = o_rdy;
    assign o_first = o_rdy && (seg_cnt_q == '0);
    assign o_last  = o_rdy && (seg_cnt_q == LAST_CNT);
    assign o_data  = shreg_q[SEG_DW_M1:0];

    // Accepting a new word while the last segment leaves is what removes the bubble.
    assign i_ack  = !o_rdy || (o_ack && o_last);
    assign i_deal = i_rdy && i_ack;
    assign o_deal = o_rdy && o_ack;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        shreg_d   = shreg_q;
        seg_cnt_d = seg_cnt_q;
        if (i_deal) begin
            shreg_d   = i_data;
            seg_cnt_d = '0;
            state_d   = SEND;
        end else if (o_deal && !o_last) begin
            shreg_d   = shreg_q >> SEG_W;
            seg_cnt_d = seg_cnt_q + CW'(1);
        end else if (o_deal) begin
            // Last segment gone with no replacement: shreg is held so o_data keeps its value.
            state_d   = IDLE;
            seg_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath register is reset too, so o_data reads 0 straight out of reset.
            state_q   <= IDLE;
            shreg_q   <= '0;
            seg_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            seg_cnt_q <= seg_cnt_d;
        end
    end

endmodule

// File: tb/tb_rdy_ack_serializer.sv
// Scoreboard bench for rdy_ack_serializer: a 4x8 instance and a 1x8 (single-segment) instance
// are driven with random rdy/ack traffic and checked against queues of expected segments.
`timescale 1ns/1ps
module tb_rdy_ack_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        i_rdy, i_ack, o_rdy, o_ack, o_first, o_last, busy;
    logic [31:0] i_data;
    logic [7:0]  o_data;

    logic        b_i_rdy, b_i_ack, b_o_rdy, b_o_ack, b_o_first, b_o_last, b_busy;
    logic [7:0]  b_i_data, b_o_data;

    rdy_ack_serializer #(.SEG_DW_M1(7), .SEG_N_M1(3), .IN_DW_M1(31), .CW_M1(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_rdy(i_rdy), .i_ack(i_ack), .i_data(i_data),
        .o_rdy(o_rdy), .o_ack(o_ack), .o_data(o_data),
        .o_first(o_first), .o_last(o_last), .busy(busy)
    );

    rdy_ack_serializer #(.SEG_DW_M1(7), .SEG_N_M1(0), .IN_DW_M1(7), .CW_M1(0)) u_byte (
        .clk(clk), .rst_n(rst_n),
        .i_rdy(b_i_rdy), .i_ack(b_i_ack), .i_data(b_i_data),
        .o_rdy(b_o_rdy), .o_ack(b_o_ack), .o_data(b_o_data),
        .o_first(b_o_first), .o_last(b_o_last), .busy(b_busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       first;
        logic       last;
    } seg_t;

    logic [31:0] src_q[$];
    seg_t        exp_q[$];
    logic [7:0]  src1_q[$];
    logic [7:0]  exp1_q[$];

    int total = 0;
    int bad   = 0;
    int rdy_pct = 100;
    int ack_pct = 100;
    bit mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: new inputs shortly after each rising edge; i_data is junk whenever i_rdy is low.
    initial begin
        i_rdy = 1'b0; i_data = '0; o_ack = 1'b0;
        b_i_rdy = 1'b0; b_i_data = '0; b_o_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_rdy    = (src_q.size() > 0) && ($urandom_range(0, 99) < rdy_pct);
            i_data   = i_rdy ? src_q[0] : $urandom();
            o_ack    = ($urandom_range(0, 99) < ack_pct);
            b_i_rdy  = (src1_q.size() > 0) && ($urandom_range(0, 99) < rdy_pct);
            b_i_data = b_i_rdy ? src1_q[0] : 8'($urandom());
            b_o_ack  = ($urandom_range(0, 99) < ack_pct);
        end
    end

    // Monitor: on the falling edge compare against the queue heads, then retire / enqueue
    // according to the handshakes that the next rising edge will complete.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                int n;
                n = exp_q.size();
                check("o_rdy", 32'(o_rdy), 32'(n > 0));
                check("busy", 32'(busy), 32'(n > 0));
                check("i_ack", 32'(i_ack), 32'((n == 0) || (n == 1 && o_ack)));
                if (o_rdy && n > 0) begin
                    check("o_data", 32'(o_data), 32'(exp_q[0].data));
                    check("o_first", 32'(o_first), 32'(exp_q[0].first));
                    check("o_last", 32'(o_last), 32'(exp_q[0].last));
                    if (o_ack) void'(exp_q.pop_front());
                end
                if (i_rdy && i_ack && src_q.size() > 0) begin
                    logic [31:0] w;
                    w = src_q.pop_front();
                    for (int k = 0; k < 4; k++) begin
                        seg_t s;
                        s.data  = w[8*k +: 8];
                        s.first = (k == 0);
                        s.last  = (k == 3);
                        exp_q.push_back(s);
                    end
                end

                n = exp1_q.size();
                check("b_o_rdy", 32'(b_o_rdy), 32'(n > 0));
                check("b_o_first", 32'(b_o_first), 32'(n > 0));
                check("b_o_last", 32'(b_o_last), 32'(n > 0));
                check("b_i_ack", 32'(b_i_ack), 32'((n == 0) || b_o_ack));
                if (b_o_rdy && n > 0) begin
                    check("b_o_data", 32'(b_o_data), 32'(exp1_q[0]));
                    if (b_o_ack) void'(exp1_q.pop_front());
                end
                if (b_i_rdy && b_i_ack && src1_q.size() > 0)
                    exp1_q.push_back(src1_q.pop_front());
            end
        end
    end

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((src_q.size() + exp_q.size() + src1_q.size() + exp1_q.size()) > 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("drain", 32'(src_q.size() + exp_q.size() + src1_q.size() + exp1_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_o_rdy"}, 32'(o_rdy), 32'd0);
        check({tag, "_o_data"}, 32'(o_data), 32'd0);
        check({tag, "_o_first"}, 32'(o_first), 32'd0);
        check({tag, "_o_last"}, 32'(o_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_i_ack"}, 32'(i_ack), 32'd1);
        check({tag, "_b_o_rdy"}, 32'(b_o_rdy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst0");
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        // Single word at full rate, then two words back to back.
        src_q.push_back(32'h4433_2211);
        drain(50);
        src_q.push_back(32'hDDCC_BBAA);
        src_q.push_back(32'h0403_0201);
        drain(50);

        // Downstream stalls while a second word waits upstream.
        src_q.push_back(32'h4433_2211);
        src_q.push_back(32'h8877_6655);
        ack_pct = 100;
        repeat (3) @(posedge clk);
        ack_pct = 0;
        repeat (5) @(posedge clk);
        ack_pct = 100;
        drain(50);

        // Asynchronous reset in the middle of a word.
        rdy_pct = 100;
        ack_pct = 50;
        for (int i = 0; i < 4; i++) src_q.push_back($urandom());
        for (int i = 0; i < 4; i++) src1_q.push_back(8'($urandom()));
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        src_q.delete(); exp_q.delete(); src1_q.delete(); exp1_q.delete();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        // Random traffic: 1000 incrementing words plus random bytes on the single-segment slice.
        for (int i = 0; i < 1000; i++) src_q.push_back(32'(i) * 32'h0101_0101 + 32'h0302_0100);
        for (int i = 0; i < 300; i++) src1_q.push_back(8'($urandom()));
        for (int p = 0; p < 4; p++) begin
            rdy_pct = $urandom_range(30, 100);
            ack_pct = $urandom_range(30, 100);
            repeat (1500) @(posedge clk);
        end
        rdy_pct = 100;
        ack_pct = 100;
        drain(10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
